// File: rtl/sync_edge_event_queue_if.sv
// sync_edge_event_queue_if: valid/ready event bus from the edge-event queue to its consumer
// Signals:
//   evt_valid  queue holds at least one event
//   evt_ready  consumer accepts the head entry
//   evt_pol    head polarity, 1 = rising, 0 = falling
//   evt_ts     head timestamp (TS_W bits)
// master = event queue, slave = consumer.
interface sync_edge_event_queue_if #(
  parameter int TS_W = 8
);
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_pol;
  logic [TS_W-1:0] evt_ts;
  modport master (output evt_valid, evt_pol, evt_ts, input evt_ready);
  modport slave  (input evt_valid, evt_pol, evt_ts, output evt_ready);
endinterface

// File: rtl/sync_edge_event_queue.sv
// sync_edge_event_queue: glitch-filtered edge detector queuing timestamped edge events in a FIFO
// Ports:
//   clk2          destination-domain clock, rising edge
//   rst           asynchronous active-high reset
//   in            synchronized input level
//   level         filtered level
//   overflow      sticky, set when an event is dropped on a full queue
//   clr_overflow  synchronous clear for overflow (a same-cycle drop wins)
//   evt           event bus (master modport): evt_valid/evt_ready/evt_pol/evt_ts
// Configuration: macro SYNC_EDGE_GLITCH_FILTER_EN enables the STABLE_CYCLES glitch
// filter; without it level follows in with one cycle of latency.
module sync_edge_event_queue #(
  parameter int STABLE_CYCLES = 3,
  parameter int DEPTH         = 4,
  parameter int TS_W          = 8
) (
  input  logic                   clk2,
  input  logic                   rst,
  input  logic                   in,
  input  logic                   clr_overflow,
  output logic                   level,
  output logic                   overflow,
  sync_edge_event_queue_if.master evt
);
  localparam int AW = $clog2(DEPTH);
  logic [TS_W-1:0] ts_q;
  logic            level_q;
  logic            level_d;
  logic            flip;
  logic [AW:0]     wr_q, wr_d;
  logic [AW:0]     rd_q, rd_d;
  logic            pol_q [DEPTH];
  logic [TS_W-1:0] tsm_q [DEPTH];
  logic            ovf_q, ovf_d;
  logic            empty, full, push, pop, drop;
`ifdef SYNC_EDGE_GLITCH_FILTER_EN
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // level flips on the STABLE_CYCLES-th consecutive differing sample
  always_comb begin
    flip  = (in != level_q) && (cnt_q == CW'(STABLE_CYCLES - 1));
    cnt_d = (in == level_q || flip) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_stable;
  assign unused_stable = ^STABLE_CYCLES;
  assign flip          = in != level_q;
`endif
  // the extra pointer bit separates full (MSBs differ) from empty (equal)
  always_comb begin
    empty   = wr_q == rd_q;
    full    = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    pop     = !empty && evt.evt_ready;
    push    = flip && (!full || pop);
    drop    = flip && full && !pop;
    level_d = flip ? in : level_q;
    wr_d    = wr_q + {{AW{1'b0}}, push};
    rd_d    = rd_q + {{AW{1'b0}}, pop};
    ovf_d   = drop ? 1'b1 : clr_overflow ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      ts_q    <= '0;
      level_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pol_q[i] <= 1'b0;
        tsm_q[i] <= '0;
      end
    end else begin
      ts_q    <= ts_q + 1'b1;
      level_q <= level_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      if (push) begin
        pol_q[wr_q[AW-1:0]] <= in;
        tsm_q[wr_q[AW-1:0]] <= ts_q;
      end
    end
  end
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign evt.evt_valid = !empty;
  assign evt.evt_pol   = pol_q[rd_q[AW-1:0]];
  assign evt.evt_ts    = tsm_q[rd_q[AW-1:0]];
endmodule

// File: tb/tb_sync_edge_event_queue.sv
// tb_sync_edge_event_queue: randomized self-checking bench against a queue-based reference model
module tb_sync_edge_event_queue;
`ifdef SYNC_EDGE_GLITCH_FILTER_EN
  localparam int SC = 3;
`else
  localparam int SC = 1;
`endif
  localparam int DEPTH = 4;
  typedef struct {
    bit       pol;
    bit [7:0] ts;
  } ev_t;
  logic clk2 = 1'b0;
  logic rst, in, clr;
  logic level, overflow;
  int   errors = 0;
  int   checks = 0;
  ev_t  mq[$];
  bit   hist[$];
  bit   m_level, m_ovf;
  int   cyc;
  sync_edge_event_queue_if #(.TS_W(8)) bus ();
  sync_edge_event_queue #(.STABLE_CYCLES(3), .DEPTH(DEPTH), .TS_W(8)) dut (
    .clk2(clk2), .rst(rst), .in(in), .clr_overflow(clr),
    .level(level), .overflow(overflow), .evt(bus)
  );
  always #5 clk2 = ~clk2;
  function automatic void m_reset();
    mq.delete();
    hist.delete();
    m_level = 0;
    m_ovf   = 0;
    cyc     = 0;
  endfunction
  // level changes once the last SC samples since reset all disagree with it
  function automatic bit will_flip(bit x);
    bit t[$];
    t = hist;
    t.push_back(x);
    if (t.size() > SC) void'(t.pop_front());
    if (t.size() < SC) return 0;
    foreach (t[i]) if (t[i] == m_level) return 0;
    return 1;
  endfunction
  task automatic step();
    bit fl, pp, drop;
    fl   = will_flip(in);
    pp   = (mq.size() > 0) && bus.evt_ready;
    drop = 0;
    hist.push_back(in);
    if (hist.size() > SC) void'(hist.pop_front());
    if (pp) void'(mq.pop_front());
    if (fl) begin
      m_level = in;
      if (mq.size() < DEPTH) mq.push_back('{pol: in, ts: 8'(cyc % 256)});
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    cyc++;
    @(posedge clk2);
    #1;
  endtask
  task automatic test_reset();
    rst = 1; in = 1; clr = 0; bus.evt_ready = 0;
    m_reset();
    repeat (3) @(posedge clk2);
    #1;
    checks++; if (level !== 1'b0) begin errors++; $display("FAIL reset level: got %0b want 0", level); end
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %0b want 0", bus.evt_valid); end
    checks++; if (bus.evt_pol !== 1'b0) begin errors++; $display("FAIL reset pol: got %0b want 0", bus.evt_pol); end
    checks++; if (bus.evt_ts !== 8'd0) begin errors++; $display("FAIL reset ts: got %0d want 0", bus.evt_ts); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %0b want 0", overflow); end
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (level !== m_level) begin errors++; $display("FAIL reset_rel level step %0d: got %0b want %0b", k, level, m_level); end
      checks++; if (bus.evt_valid !== (mq.size() > 0)) begin errors++; $display("FAIL reset_rel valid step %0d: got %0b want %0b", k, bus.evt_valid, mq.size() > 0); end
    end
    checks++; if (bus.evt_pol !== 1'b1) begin errors++; $display("FAIL reset_rel pol: got %0b want 1", bus.evt_pol); end
    checks++; if (bus.evt_ts !== 8'(SC - 1)) begin errors++; $display("FAIL reset_rel ts: got %0d want %0d", bus.evt_ts, SC - 1); end
  endtask
  task automatic test_glitch();
    int n;
    bus.evt_ready = 1;
    in = m_level;
    repeat (6) step();
    bus.evt_ready = 0;
    in = !m_level;
    repeat (2) step();
    in = !in;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (level !== m_level) begin errors++; $display("FAIL glitch level step %0d: got %0b want %0b", k, level, m_level); end
    end
    n = 0;
    bus.evt_ready = 1;
    while (mq.size() > 0 && n < 8) begin
      checks++; if (bus.evt_valid !== 1'b1 || bus.evt_pol !== mq[0].pol || bus.evt_ts !== mq[0].ts) begin
        errors++; $display("FAIL glitch event %0d: got v%0b p%0b ts%0d want v1 p%0b ts%0d", n, bus.evt_valid, bus.evt_pol, bus.evt_ts, mq[0].pol, mq[0].ts);
      end
      step();
      n++;
    end
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL glitch drained valid: got %0b want 0", bus.evt_valid); end
  endtask
  task automatic test_overflow();
    bus.evt_ready = 0;
    for (int t = 0; t < 5; t++) begin
      in = !m_level;
      repeat (SC + 1) step();
      checks++; if (bus.evt_valid !== 1'b1 || bus.evt_pol !== mq[0].pol || bus.evt_ts !== mq[0].ts) begin
        errors++; $display("FAIL overflow head t%0d: got v%0b p%0b ts%0d want v1 p%0b ts%0d", t, bus.evt_valid, bus.evt_pol, bus.evt_ts, mq[0].pol, mq[0].ts);
      end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL overflow flag t%0d: got %0b want %0b", t, overflow, m_ovf); end
    end
    clr = 1;
    step();
    clr = 0;
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL overflow clear: got %0b want %0b", overflow, m_ovf); end
  endtask
  task automatic test_full_pop();
    int n, exp_n;
    in = !m_level;
    for (int k = 0; k < 2 * SC + 2; k++) begin
      bus.evt_ready = will_flip(in);
      step();
    end
    bus.evt_ready = 0;
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL full_pop overflow: got %0b want %0b", overflow, m_ovf); end
    exp_n = mq.size();
    n = 0;
    bus.evt_ready = 1;
    while (bus.evt_valid === 1'b1 && n < 8) begin
      checks++; if (mq.size() == 0 || bus.evt_pol !== mq[0].pol || bus.evt_ts !== mq[0].ts) begin
        errors++; $display("FAIL full_pop drain %0d: got p%0b ts%0d want p%0b ts%0d", n, bus.evt_pol, bus.evt_ts, mq[0].pol, mq[0].ts);
      end
      step();
      n++;
    end
    checks++; if (n != exp_n) begin errors++; $display("FAIL full_pop count: got %0d want %0d", n, exp_n); end
  endtask
  task automatic test_wrap();
    bus.evt_ready = 1;
    in = m_level;
    repeat (300) step();
    bus.evt_ready = 0;
    in = !m_level;
    repeat (SC) step();
    checks++; if (level !== m_level) begin errors++; $display("FAIL wrap level: got %0b want %0b", level, m_level); end
    checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ts !== mq[0].ts) begin
      errors++; $display("FAIL wrap ts: got v%0b ts%0d want v1 ts%0d", bus.evt_valid, bus.evt_ts, mq[0].ts);
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) in = !in;
      bus.evt_ready = ($urandom_range(2) == 0);
      clr = ($urandom_range(15) == 0);
      step();
      checks++; if (level !== m_level) begin errors++; $display("FAIL random level c%0d: got %0b want %0b", k, level, m_level); end
      checks++; if (bus.evt_valid !== (mq.size() > 0)) begin errors++; $display("FAIL random valid c%0d: got %0b want %0b", k, bus.evt_valid, mq.size() > 0); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL random overflow c%0d: got %0b want %0b", k, overflow, m_ovf); end
      if (mq.size() > 0) begin
        checks++; if (bus.evt_pol !== mq[0].pol || bus.evt_ts !== mq[0].ts) begin
          errors++; $display("FAIL random head c%0d: got p%0b ts%0d want p%0b ts%0d", k, bus.evt_pol, bus.evt_ts, mq[0].pol, mq[0].ts);
        end
      end
    end
    clr = 0;
  endtask
  task automatic test_async_reset();
    bus.evt_ready = 1;
    repeat (8) step();
    bus.evt_ready = 0;
    for (int t = 0; t < 2; t++) begin
      in = !m_level;
      repeat (SC + 1) step();
    end
    in = !m_level;
    repeat (2) step();
    #3;
    rst = 1;
    #1;
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL async valid: got %0b want 0", bus.evt_valid); end
    checks++; if (level !== 1'b0) begin errors++; $display("FAIL async level: got %0b want 0", level); end
    m_reset();
    repeat (2) @(posedge clk2);
    #3;
    in = 0;
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (bus.evt_valid !== 1'b0 || level !== 1'b0) begin
        errors++; $display("FAIL async stale c%0d: got v%0b l%0b want v0 l0", k, bus.evt_valid, level);
      end
    end
    in = 1;
    repeat (SC) step();
    checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ts !== mq[0].ts) begin
      errors++; $display("FAIL async restart ts: got v%0b ts%0d want v1 ts%0d", bus.evt_valid, bus.evt_ts, mq[0].ts);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_glitch();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
